// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and
// the saturating status-counter increment.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser; resets asynchronously to all-zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings the main PLL out of reset on the reference clock and releases the
// system reset only once PLL lock has been stable, retrying on timeout.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 40000,
    parameter int HOLD_CYCLES         = 64,
    parameter int CNT_W               = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       clk_ready,
    output logic [1:0] seq_state,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             lock_s;
    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_resetb_q, sys_reset_q, clk_ready_q;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        stab_d  = '0;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                stab_d = lock_s ? stab_q + CNT_ONE : '0;
                // Qualified lock takes priority over a coincident timeout.
                if (lock_s && (stab_q == STAB_LAST)) begin
                    state_d = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    state_d = PLL_RST;
                    retry_d = sat_inc8(retry_q);
                end
            end
            HOLD: begin
                if (!lock_s) state_d = PLL_RST;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lock_s) begin
                    state_d = PLL_RST;
                    loss_d  = sat_inc8(loss_q);
                end
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) begin
            cnt_d  = '0;
            stab_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            stab_q       <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            clk_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stab_q       <= stab_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            // Outputs are decoded from the next state so they switch on the
            // same edge as the state register.
            pll_resetb_q <= (state_d != PLL_RST);
            sys_reset_q  <= (state_d != RUN);
            clk_ready_q  <= (state_d == RUN);
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign sys_reset       = sys_reset_q;
    assign clk_ready       = clk_ready_q;
    assign seq_state       = state_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: scenario tasks plus a
// cycle-level behavioural reference model driven by randomized lock traffic.
module tb_pll_reset_sequencer;

    localparam int P_RST  = 4;
    localparam int P_STAB = 8;
    localparam int P_TO   = 50;
    localparam int P_HOLD = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_resetb, sys_reset, clk_ready;
    logic [1:0] seq_state;
    logic [7:0] retry_count, lock_loss_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase number, cycles spent in phase, run of
    // consecutive synchronised-high lock samples, status counts.
    int   m_st, m_t, m_run, m_retry, m_loss;
    logic m_s1, m_s2;

    localparam logic [20:0] RESET_VEC = {1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0};

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STAB),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .HOLD_CYCLES         (P_HOLD),
        .CNT_W               (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_lock        (pll_lock),
        .pll_resetb      (pll_resetb),
        .sys_reset       (sys_reset),
        .clk_ready       (clk_ready),
        .seq_state       (seq_state),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_st = 0; m_t = 0; m_run = 0; m_retry = 0; m_loss = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_edge();
        logic ls;
        int   nxt;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_lock;
        nxt  = m_st;
        case (m_st)
            0: begin
                m_t++;
                if (m_t == P_RST) nxt = 1;
            end
            1: begin
                m_t++;
                m_run = ls ? m_run + 1 : 0;
                if (m_run == P_STAB) nxt = 2;
                else if (m_t == P_TO) begin
                    nxt = 0;
                    if (m_retry < 255) m_retry++;
                end
            end
            2: begin
                if (!ls) nxt = 0;
                else begin
                    m_t++;
                    if (m_t == P_HOLD) nxt = 3;
                end
            end
            default: begin
                if (!ls) begin
                    nxt = 0;
                    if (m_loss < 255) m_loss++;
                end
            end
        endcase
        if (nxt != m_st) begin
            m_t   = 0;
            m_run = 0;
        end
        m_st = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_clear();
        else model_edge();
        @(negedge clk);
    endtask

    function automatic logic [20:0] dut_vec();
        return {pll_resetb, sys_reset, clk_ready, seq_state, retry_count, lock_loss_count};
    endfunction

    function automatic logic [20:0] exp_vec();
        return {(m_st != 0), (m_st != 3), (m_st == 3), 2'(m_st), 8'(m_retry), 8'(m_loss)};
    endfunction

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        model_clear();
        n_vec++;
        if (dut_vec() !== RESET_VEC) begin
            n_err++;
            $display("FAIL reset_async: got %h, expected %h", dut_vec(), RESET_VEC);
        end
        repeat (2) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_hold: got %h, expected %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_happy_path();
        int n;
        reset = 1'b0;
        pll_lock = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL happy_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (pll_resetb) break;
        end
        n_vec++;
        if (n !== P_RST) begin
            n_err++;
            $display("FAIL happy_resetb_low: got %0d cycles, expected %0d", n, P_RST);
        end
        repeat (10 - P_RST) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL happy_wait_model: got %h, expected %h", dut_vec(), exp_vec());
            end
        end
        pll_lock = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL happy_lock_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (clk_ready) break;
        end
        n_vec++;
        if (n !== 2 + P_STAB + P_HOLD) begin
            n_err++;
            $display("FAIL happy_ready_latency: got %0d, expected %0d", n, 2 + P_STAB + P_HOLD);
        end
        n_vec++;
        if ({sys_reset, clk_ready, retry_count} !== {1'b0, 1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL happy_run_outputs: got %b/%b/%0d, expected 0/1/0",
                     sys_reset, clk_ready, retry_count);
        end
    endtask

    task automatic test_lock_loss_run();
        int n;
        pll_lock = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL loss_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (sys_reset && !clk_ready) break;
        end
        n_vec++;
        if (!(n >= 1 && n <= 3) || lock_loss_count !== 8'd1 || seq_state !== 2'd0) begin
            n_err++;
            $display("FAIL loss_response: got %0d edges cnt=%0d st=%0d, expected <=3 edges cnt=1 st=0",
                     n, lock_loss_count, seq_state);
        end
        pll_lock = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL loss_rst_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (pll_resetb) break;
        end
        n_vec++;
        if (n !== P_RST) begin
            n_err++;
            $display("FAIL loss_resetb_low: got %0d, expected %0d", n, P_RST);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL loss_relock_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (clk_ready) break;
        end
        n_vec++;
        if (clk_ready !== 1'b1) begin
            n_err++;
            $display("FAIL loss_relock_run: got clk_ready=%b, expected 1", clk_ready);
        end
    endtask

    task automatic test_hold_loss();
        int  n;
        bit  saw_ready;
        logic [1:0] first_st;
        pll_lock = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL hold_drop_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (seq_state == 2'd0) break;
        end
        pll_lock = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL hold_reach_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (seq_state == 2'd2) break;
        end
        pll_lock = 1'b0;
        saw_ready = 1'b0;
        n = 0;
        first_st = 2'd2;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL hold_loss_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (clk_ready) saw_ready = 1'b1;
            if (n == 0 && seq_state != 2'd2) begin
                n = i + 1;
                first_st = seq_state;
            end
        end
        n_vec++;
        if (saw_ready || first_st !== 2'd0 || n < 1 || n > 3 || lock_loss_count !== 8'd2) begin
            n_err++;
            $display("FAIL hold_loss: got ready=%b next_st=%0d after %0d cnt=%0d, expected ready=0 st=0 <=3 cnt=2",
                     saw_ready, first_st, n, lock_loss_count);
        end
    endtask

    task automatic test_async_reset();
        int n;
        pll_lock = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL arst_reach_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (seq_state == 2'd2) break;
        end
        tick();
        #2 reset = 1'b1;
        #1;
        model_clear();
        n_vec++;
        if (dut_vec() !== RESET_VEC) begin
            n_err++;
            $display("FAIL arst_hold: got %h, expected %h", dut_vec(), RESET_VEC);
        end
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL arst_restart_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (pll_resetb) break;
        end
        n_vec++;
        if (n !== P_RST) begin
            n_err++;
            $display("FAIL arst_restart_low: got %0d, expected %0d", n, P_RST);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL arst_run_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (clk_ready) break;
        end
        #2 reset = 1'b1;
        #1;
        model_clear();
        n_vec++;
        if (dut_vec() !== RESET_VEC) begin
            n_err++;
            $display("FAIL arst_run: got %h, expected %h", dut_vec(), RESET_VEC);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_never_lock();
        int want;
        pll_lock = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 1; a <= 257; a++) begin
            repeat (P_RST + P_TO) begin
                tick();
                n_vec++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL nolock_model: got %h, expected %h", dut_vec(), exp_vec());
                end
            end
            want = (a > 255) ? 255 : a;
            n_vec++;
            if (retry_count !== 8'(want) || seq_state !== 2'd0) begin
                n_err++;
                $display("FAIL nolock_retry: attempt %0d got cnt=%0d st=%0d, expected cnt=%0d st=0",
                         a, retry_count, seq_state, want);
            end
        end
    endtask

    task automatic test_chatter();
        int n;
        pll_lock = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pll_resetb) break;
        end
        pll_lock = 1'b1;
        repeat (6) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL chatter_high_model: got %h, expected %h", dut_vec(), exp_vec());
            end
        end
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL chatter_model: got %h, expected %h", dut_vec(), exp_vec());
            end
            if (seq_state == 2'd2) break;
        end
        n_vec++;
        if (n !== 2 + P_STAB) begin
            n_err++;
            $display("FAIL chatter_hold_entry: got %0d edges, expected %0d", n, 2 + P_STAB);
        end
    endtask

    task automatic test_random();
        int dur;
        pll_lock = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int s = 0; s < 200; s++) begin
            pll_lock = ($urandom_range(0, 3) != 0);
            dur = $urandom_range(1, 40);
            for (int c = 0; c < dur; c++) begin
                tick();
                n_vec++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL random_model: seg %0d got %h, expected %h", s, dut_vec(), exp_vec());
                end
            end
            if ($urandom_range(0, 29) == 0) begin
                #2 reset = 1'b1;
                #1;
                model_clear();
                n_vec++;
                if (dut_vec() !== RESET_VEC) begin
                    n_err++;
                    $display("FAIL random_arst: got %h, expected %h", dut_vec(), RESET_VEC);
                end
                tick();
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_happy_path();
        test_lock_loss_run();
        test_hold_loss();
        test_async_reset();
        test_chatter();
        test_never_lock();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
